// File: rtl/r2sdf_pkg.sv
// r2sdf_pkg: shared types, defaults and saturation helper for the
// R2SDF FFT stage (state enum, DW/TW/TF defaults, sat()).
package r2sdf_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 8;
    localparam int TF_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BF   = 2'd2,
        MUL  = 2'd3
    } state_e;

    // Clamp a sign-extended value to the signed range of w bits.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/r2sdf_delay_line.sv
// r2sdf_delay_line: enable-gated DEPTH-entry shift register of complex words.
// Ports: clk, rst_n (async), clear (sync), en_i, tail_i (push), head_o (oldest).
module r2sdf_delay_line #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en_i,
    input  logic [2*DW-1:0] tail_i,
    output logic [2*DW-1:0] head_o
);

    logic [2*DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            mem_q[0] <= tail_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign head_o = mem_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: one radix-2 single-path delay-feedback FFT stage.
// Ports: clk, rst_n (async), clear (sync), in_valid/in_r/in_i (sample in),
//   tw_idx -> tw_r/tw_i (twiddle lookup), out_valid/out_r/out_i/out_last.
// Optional: define R2SDF_ROUND_EN for round-half-up on the multiplier.
module r2sdf_stage
    import r2sdf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int TW    = TW_DEF,
    parameter int TF    = TF_DEF,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tw_idx,
    input  logic signed [TW-1:0] tw_r,
    input  logic signed [TW-1:0] tw_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 out_last
);

    localparam int CW = $clog2(2 * DEPTH);
    localparam int PW = DW + TW + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;

    logic          accept;
    logic          last_lo;
    logic          last_hi;
    logic          ph_bf;
    logic          ph_mul;

    assign accept  = in_valid & ~clear;
    assign last_lo = (cnt_q == CW'(DEPTH - 1));
    assign last_hi = (cnt_q == CW'(2 * DEPTH - 1));
    assign ph_bf   = (state_q == BF);
    assign ph_mul  = (state_q == MUL) & pend_q;

    generate
        if (DEPTH > 1) begin : g_k
            assign tw_idx = cnt_q[$bits(tw_idx)-1:0];
        end else begin : g_k0
            assign tw_idx = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else if (in_valid) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                IDLE, FILL: begin
                    state_d = last_lo ? BF : FILL;
                end
                BF: begin
                    if (last_hi) begin
                        state_d = MUL;
                        pend_d  = 1'b1;
                    end
                end
                MUL: begin
                    // The counter wrap always lands the next half in BF,
                    // so the pending-difference flag stays set.
                    if (last_lo) begin
                        state_d = BF;
                        pend_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    logic [2*DW-1:0]      head;
    logic [2*DW-1:0]      tail;
    logic signed [DW-1:0] b_r, b_i;

    assign b_r = head[2*DW-1:DW];
    assign b_i = head[DW-1:0];

    r2sdf_delay_line #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_dl (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .en_i   (accept),
        .tail_i (tail),
        .head_o (head)
    );

    logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
    logic signed [DW-1:0] sum_rs, sum_is, dif_rs, dif_is;

    assign sum_r  = (DW+1)'(b_r) + (DW+1)'(in_r);
    assign sum_i  = (DW+1)'(b_i) + (DW+1)'(in_i);
    assign dif_r  = (DW+1)'(b_r) - (DW+1)'(in_r);
    assign dif_i  = (DW+1)'(b_i) - (DW+1)'(in_i);
    assign sum_rs = DW'(sat(64'(sum_r), DW));
    assign sum_is = DW'(sat(64'(sum_i), DW));
    assign dif_rs = DW'(sat(64'(dif_r), DW));
    assign dif_is = DW'(sat(64'(dif_i), DW));

    // During BF the delay line takes the difference for the next MUL half.
    assign tail = ph_bf ? {dif_rs, dif_is} : {in_r, in_i};

    logic signed [PW-1:0] p_r, p_i, q_r, q_i;
    logic signed [DW-1:0] mul_r, mul_i;

    assign p_r = PW'(b_r) * PW'(tw_r) - PW'(b_i) * PW'(tw_i);
    assign p_i = PW'(b_r) * PW'(tw_i) + PW'(b_i) * PW'(tw_r);

`ifdef R2SDF_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1 << (TF - 1));
    assign q_r = (p_r + RND) >>> TF;
    assign q_i = (p_i + RND) >>> TF;
`else
    assign q_r = p_r >>> TF;
    assign q_i = p_i >>> TF;
`endif

    assign mul_r = DW'(sat(64'(q_r), DW));
    assign mul_i = DW'(sat(64'(q_i), DW));

    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic signed [DW-1:0] out_r_q, out_r_d;
    logic signed [DW-1:0] out_i_q, out_i_d;

    always_comb begin
        out_valid_d = accept & (ph_bf | ph_mul);
        out_last_d  = accept & ((ph_bf & last_hi) | (ph_mul & last_lo));
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        if (accept & ph_bf) begin
            out_r_d = sum_rs;
            out_i_d = sum_is;
        end else if (accept & ph_mul) begin
            out_r_d = mul_r;
            out_i_d = mul_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: randomized and directed bench for r2sdf_stage (DEPTH=4),
// plus a short DEPTH=1 instance; outputs are checked against a history model.
module tb_r2sdf_stage;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_r = '0;
    logic signed [15:0] in_i = '0;
    logic [1:0] tw_idx;
    logic signed [7:0] tw_r, tw_i;
    logic out_valid, out_last;
    logic signed [15:0] out_r, out_i;
    logic signed [7:0] twr [D];
    logic signed [7:0] twi [D];

    assign tw_r = twr[tw_idx];
    assign tw_i = twi[tw_idx];

    r2sdf_stage #(.DW(16), .TW(8), .TF(6), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_r(in_r), .in_i(in_i), .tw_idx(tw_idx), .tw_r(tw_r), .tw_i(tw_i),
        .out_valid(out_valid), .out_r(out_r), .out_i(out_i),
        .out_last(out_last)
    );

    logic clear1 = 1'b0;
    logic in_valid1 = 1'b0;
    logic signed [15:0] in1_r = '0;
    logic signed [15:0] in1_i = '0;
    logic [0:0] tw_idx1;
    logic signed [7:0] tw1_r, tw1_i;
    logic out_valid1, out_last1;
    logic signed [15:0] out1_r, out1_i;

    assign tw1_r = 8'sd64;
    assign tw1_i = 8'sd0;

    r2sdf_stage #(.DW(16), .TW(8), .TF(6), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1),
        .in_r(in1_r), .in_i(in1_i), .tw_idx(tw_idx1), .tw_r(tw1_r),
        .tw_i(tw1_i), .out_valid(out_valid1), .out_r(out1_r),
        .out_i(out1_i), .out_last(out_last1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int mres(input longint a);
        longint t;
        t = a;
`ifdef R2SDF_ROUND_EN
        t = t + 32;
`endif
        return sat16(t >>> 6);
    endfunction

    int hq_r[$];
    int hq_i[$];
    bit e_v = 1'b0;
    bit e_l = 1'b0;
    int e_r = 0;
    int e_i = 0;
    int got_r[$];
    int got_i[$];
    int got_l[$];

    // Expected output of sample n follows from the accepted-sample history:
    // second half of a 2D block -> x[n-D]+x[n]; later first halves ->
    // (x[n-2D]-x[n-D]) * W[n mod D].
    task automatic step(input bit v, input bit clr, input int xr, input int xi);
        int n, j, br, bi;
        @(negedge clk);
        in_valid = v;
        clear = clr;
        in_r = 16'(xr);
        in_i = 16'(xi);
        n = hq_r.size();
        j = n % (2 * D);
        if (!clr) chk("tw_idx", longint'(tw_idx), n % D);
        e_v = 1'b0;
        e_l = 1'b0;
        if (clr) begin
            hq_r.delete();
            hq_i.delete();
        end else if (v) begin
            if (n >= D && j >= D) begin
                e_v = 1'b1;
                e_r = sat16(longint'(hq_r[n-D]) + xr);
                e_i = sat16(longint'(hq_i[n-D]) + xi);
            end else if (n >= 2 * D) begin
                br = sat16(longint'(hq_r[n-2*D]) - hq_r[n-D]);
                bi = sat16(longint'(hq_i[n-2*D]) - hq_i[n-D]);
                e_r = mres(longint'(br) * twr[j] - longint'(bi) * twi[j]);
                e_i = mres(longint'(br) * twi[j] + longint'(bi) * twr[j]);
                e_v = 1'b1;
            end
            e_l = e_v && ((j % D) == D - 1);
            hq_r.push_back(xr);
            hq_i.push_back(xi);
        end
    endtask

    always begin : cmp
        bit v, l;
        int r, i;
        @(posedge clk);
        v = e_v;
        l = e_l;
        r = e_r;
        i = e_i;
        #2;
        chk("out_valid", out_valid, v);
        chk("out_last", out_last, l);
        if (v) begin
            chk("out_r", out_r, r);
            chk("out_i", out_i, i);
        end
        if (out_valid) begin
            got_r.push_back(int'(out_r));
            got_i.push_back(int'(out_i));
            got_l.push_back(int'(out_last));
        end
    end

    task automatic set_tw(input int wr, input int wi);
        for (int k = 0; k < D; k++) begin
            twr[k] = 8'(wr);
            twi[k] = 8'(wi);
        end
    endtask

    task automatic ramp(input bit gap, input string tag);
        int exp_r[8] = '{256, 384, 512, 640, -256, -256, -256, -256};
        got_r.delete();
        got_i.delete();
        got_l.delete();
        for (int s = 0; s < 12; s++) begin
            step(1'b1, 1'b0, (s < 8) ? s * 64 : 0, 0);
            if (gap) step(1'b0, 1'b0, 0, 0);
        end
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk({tag, "_count"}, got_r.size(), 8);
        for (int i = 0; i < 8 && i < got_r.size(); i++) begin
            chk({tag, "_r"}, got_r[i], exp_r[i]);
            chk({tag, "_last"}, got_l[i], (i == 3 || i == 7) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int d1_in[5] = '{10, 3, 0, 5, 7};
        int d1_v[5] = '{0, 1, 1, 1, 1};
        int d1_r[5] = '{0, 13, 7, 5, -5};
        int n0;
        set_tw(64, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_r", out_r, 0);
        chk("rst_i", out_i, 0);
        chk("rst_tw_idx", tw_idx, 0);
        rst_n = 1'b1;

        // DEPTH=1: phases alternate, every output closes its half.
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in1_r = 16'(d1_in[s]);
            chk("d1_tw_idx", tw_idx1, 0);
            @(posedge clk);
            #2;
            chk("d1_valid", out_valid1, d1_v[s]);
            if (d1_v[s] != 0) begin
                chk("d1_r", out1_r, d1_r[s]);
                chk("d1_last", out_last1, 1);
            end
        end
        @(negedge clk);
        in_valid1 = 1'b0;

        ramp(1'b0, "ramp");

        step(1'b1, 1'b1, 999, 999);
        ramp(1'b1, "gap");

        // Saturation in both add and subtract paths.
        step(1'b1, 1'b1, 0, 0);
        got_r.delete();
        got_i.delete();
        for (int s = 0; s < 8; s++) step(1'b1, 1'b0, 32767, -32768);
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("sat_count", got_r.size(), 8);
        if (got_r.size() >= 5) begin
            chk("sat_bf_r", got_r[0], 32767);
            chk("sat_bf_i", got_i[0], -32768);
            chk("sat_dif_r", got_r[4], 0);
            chk("sat_dif_i", got_i[4], 0);
        end

        // Multiplier rounding with W = 0.5.
        set_tw(32, 0);
        step(1'b1, 1'b1, 0, 0);
        got_r.delete();
        got_i.delete();
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 1, -1);
        for (int s = 0; s < 8; s++) step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("rnd_count", got_r.size(), 8);
        if (got_r.size() >= 8) begin
`ifdef R2SDF_ROUND_EN
            chk("rnd_pos", got_r[4], 1);
            chk("rnd_neg", got_i[7], 0);
`else
            chk("rnd_pos", got_r[4], 0);
            chk("rnd_neg", got_i[7], -1);
`endif
        end

        // clear at cnt=5 drops the sample and restarts filling.
        set_tw(64, 0);
        step(1'b1, 1'b1, 0, 0);
        for (int s = 0; s < 5; s++) step(1'b1, 1'b0, 100 + s, 7);
        step(1'b1, 1'b1, 55, 55);
        n0 = got_r.size();
        step(1'b0, 1'b0, 0, 0);
        chk("clr_tw_idx", tw_idx, 0);
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 300, -300);
        step(1'b0, 1'b0, 0, 0);
        chk("clr_no_out", got_r.size(), n0);

        // Asynchronous reset in the middle of a BF half.
        step(1'b1, 1'b1, 0, 0);
        for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 100, 0);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        e_v = 1'b0;
        e_l = 1'b0;
        hq_r.delete();
        hq_i.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_r", out_r, 0);
        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ramp(1'b0, "post_rst");

        // Randomized traffic with random twiddles and sporadic clears.
        for (int k = 0; k < D; k++) begin
            twr[k] = 8'($urandom);
            twi[k] = 8'($urandom);
        end
        step(1'b1, 1'b1, 0, 0);
        for (int s = 0; s < 600; s++) begin
            int xr, xi;
            if ($urandom_range(0, 9) == 0) begin
                xr = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                xi = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            end else begin
                xr = int'($signed(16'($urandom)));
                xi = int'($signed(16'($urandom)));
            end
            step($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0, xr, xi);
        end
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/r2sdf_stage.md
# r2sdf_stage

Parametrised radix-2 single-path delay-feedback (R2SDF) FFT stage with its own feedback delay line, phase sequencer, twiddle addressing, valid handshake, and saturating fixed-point arithmetic. One instance forms one pipeline stage of the FFT processor. A 32-point transform cascades five instances with DEPTH = 16, 8, 4, 2, 1. The output register supplies the full-cycle timing boundary to the next stage.

## Interface
- DW, 16: data width per real/imag component; two's complement, DW-TF integer bits.
- TW, 8: twiddle width per component; two's complement.
- TF, 6: fractional bits of both data and twiddle.
- DEPTH, 16: delay-line length (N/2 for this stage); power of two, ≥1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous reset of sequencer and delay line; higher priority than in_valid.
- in_valid  in  1  sample accepted this cycle; no backpressure.
- in_r, in_i  in  DW  input sample.
- tw_idx  out  log2(DEPTH) (min 1)  twiddle index k; combinational from counter.
- tw_r, tw_i  in  TW  twiddle W^k for tw_idx, same cycle.
- out_valid  out  1  registered output valid.
- out_r, out_i  out  DW  registered output sample.
- out_last  out  1  registered; marks final output of a DEPTH-long output half.

## Operation
- Counter cnt, modulo 2·DEPTH, advances only on accepted samples (in_valid=1, clear=0). Low log2(DEPTH) bits form k = tw_idx.
- Flag pend=1 means the delay line holds a complete half of butterfly differences.
- FSM states, evaluated on the current state when a sample is accepted:
  - IDLE: after reset or clear. First accepted sample moves to FILL.
  - FILL (cnt<DEPTH, pend=0): push x into delay line. No output.
  - BF (cnt≥DEPTH): B = delay-line head, A = x. Output sat(B+A). Push sat(B−A). Set pend=1 on the last BF sample.
  - MUL (cnt<DEPTH, pend=1): output sat(rnd(B·W^k)). Push x. Clear pend on the last MUL sample if the following half is not BF. Because cnt wraps, MUL always follows BF.
- Transitions: FILL → BF at cnt = DEPTH−1. BF → MUL at cnt = 2·DEPTH−1. MUL → BF at cnt = DEPTH−1.
- To drain the final frame, the user supplies DEPTH further valid samples; zeros are allowed.
- Complex multiply: re = Br·Wr − Bi·Wi, im = Br·Wi + Bi·Wr. Compute at DW+TW+1 bits, take bits [DW+TF−1:TF], saturate to DW.
- Add/sub: compute at DW+1 bits, then saturate to [−2^(DW−1), 2^(DW−1)−1].
- Delay line: DEPTH×2·DW shift register. Shifts only on accepted samples, so idle cycles hold contents.

## Timing
- Reset values: out_valid=0, out_last=0, out_r=out_i=0, cnt=0, pend=0, state IDLE, delay line all zero.
- Latency: exactly 1 cycle from an accepted BF/MUL sample to out_valid=1.
- out_valid=0 on any cycle after in_valid=0, after a FILL sample, or after clear.
- out_last=1 with the output of the sample at cnt = 2·DEPTH−1 (BF) or cnt = DEPTH−1 (MUL).
- rst_n or clear mid-frame abandons the frame. The next accepted sample is treated as k=0 of FILL.
- clear together with in_valid: clear wins, and the sample is dropped.
- DEPTH=1: tw_idx is fixed 0, and phases alternate every sample.

## Configuration
- R2SDF_ROUND_EN defined: add 2^(TF−1) before dropping the TF product LSBs (round half up), then saturate.
- R2SDF_ROUND_EN undefined: truncate toward −∞; no adder.
- Add/sub paths are unaffected in both cases.

## Structure
- Package r2sdf_pkg holds:
  - the state enum (IDLE, FILL, BF, MUL);
  - the saturate function (width-generic via parameters);
  - default constants DW_DEF=16, TW_DEF=8, TF_DEF=6.
- Sub-module r2sdf_delay_line(DW, DEPTH): enable-gated shift register with clk, rst_n and clear, exposing head output and tail input.

## Test plan
All scenarios use DW=16, TW=8, TF=6, DEPTH=4, and W=64 (1.0) unless stated.
- Ramp x=0,64,…,448 (re) then 4 zeros → BF out_r 256,384,512,640, then MUL out_r −256 ×4. out_valid pattern 0000 1111 1111. out_last on the 4th and 8th outputs.
- Saturation: 0x7FFF in both halves → BF out 0x7FFF, difference 0. 0x8000 plus 0x8000 → 0x8000.
- Rounding: B=(1,0), W=(32,0) → out_r=1 with R2SDF_ROUND_EN, 0 without. B=(−1,0) → 0 vs −1.
- Gaps: insert in_valid=0 between every sample of the ramp → identical output sequence, each output 1 cycle after its sample, delay line held.
- clear asserted at cnt=5 with in_valid=1 → no output next cycle. The next 4 samples produce no output (FILL), and tw_idx restarts at 0.
- Async rst_n pulse mid-BF, asserted between clock edges → outputs 0 immediately. After release, behaviour matches a fresh start.
